// File: rtl/serial_uart_des.sv
// UART front end for des_core: 9-byte command frames in (key load / encrypt / decrypt),
// 8-byte DES results out. Also holds the iterative des_core (one Feistel round per clock).
module serial_uart_des #(
  parameter int CLK_FREQ = 50,
  parameter int BAUD     = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  output logic uart_tx,
  output logic status1,
  output logic status2,
  output logic status3,
  output logic status4
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD - 1;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_CLKS / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {S_IDLE, S_RX_CMD, S_RX_DATA, S_EXEC, S_KEY, S_DES, S_TX} st_t;

  rx_st_t      rx_st_q;
  st_t         st_q;
  logic [15:0] rx_cnt_q, tx_cnt_q;
  logic [2:0]  rx_bit_q, byte_cnt_q, tx_byte_q;
  logic [3:0]  tx_bit_q;
  logic [7:0]  rx_dat_q, cmd_q, tx_sh_q;
  logic [63:0] payload_q, key_q, result_q, des_res;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_start_q, rx_vld_q, rx_err_q;
  logic        des_start_q, des_done, rx_en, des_dec;
  logic        uart_tx_q, status1_q, status2_q, status3_q, status4_q;

  assign rx_en   = (st_q == S_IDLE) || (st_q == S_RX_CMD) || (st_q == S_RX_DATA);
  assign des_dec = (cmd_q == 8'hF0);
  assign uart_tx = uart_tx_q;
  assign status1 = status1_q;
  assign status2 = status2_q;
  assign status3 = status3_q;
  assign status4 = status4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_dat_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_start_q <= 1'b0;
      rx_vld_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_start_q <= 1'b0;
      rx_vld_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_cnt_q   <= rx_cnt_q + 16'd1;
      case (rx_st_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_en && rx_prev_q && !rx_s2_q) begin
            rx_st_q    <= R_START;
            rx_start_q <= 1'b1;
          end
        end
        R_START: if (rx_cnt_q == HALF_LAST) begin
          // A high line at the start-bit midpoint means the edge was a glitch.
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? R_IDLE : R_DATA;
        end
        R_DATA: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q <= '0;
          rx_dat_q <= {rx_s2_q, rx_dat_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
        end
        R_STOP: if (rx_cnt_q == BIT_LAST) begin
          rx_st_q  <= R_IDLE;
          rx_vld_q <= rx_s2_q;
          rx_err_q <= !rx_s2_q;
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= S_IDLE;
      cmd_q       <= '0;
      byte_cnt_q  <= '0;
      payload_q   <= '0;
      key_q       <= '0;
      result_q    <= '0;
      des_start_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      tx_sh_q     <= '0;
      uart_tx_q   <= 1'b1;
      status1_q   <= 1'b0;
      status2_q   <= 1'b0;
      status3_q   <= 1'b0;
      status4_q   <= 1'b0;
    end else begin
      des_start_q <= 1'b0;
      case (st_q)
        S_IDLE: if (rx_start_q) begin
          st_q      <= S_RX_CMD;
          status2_q <= 1'b1;
        end
        S_RX_CMD: begin
          if (rx_err_q) begin
            st_q      <= S_IDLE;
            status2_q <= 1'b0;
          end else if (rx_vld_q) begin
            cmd_q      <= rx_dat_q;
            byte_cnt_q <= '0;
            st_q       <= S_RX_DATA;
          end
        end
        S_RX_DATA: begin
          if (rx_err_q) begin
            st_q      <= S_IDLE;
            status2_q <= 1'b0;
          end else if (rx_vld_q) begin
            payload_q  <= {payload_q[55:0], rx_dat_q};
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
              st_q      <= S_EXEC;
              status2_q <= 1'b0;
              status3_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (cmd_q == 8'hFF) begin
            st_q      <= S_KEY;
            status3_q <= 1'b0;
          end else if (cmd_q == 8'h0F || cmd_q == 8'hF0) begin
            st_q        <= S_DES;
            des_start_q <= 1'b1;
          end else begin
            st_q      <= S_IDLE;
            status3_q <= 1'b0;
          end
        end
        S_KEY: begin
          key_q     <= payload_q;
          status1_q <= 1'b1;
          st_q      <= S_IDLE;
        end
        S_DES: if (des_done) begin
          tx_sh_q   <= des_res[63:56];
          result_q  <= {des_res[55:0], 8'h00};
          tx_cnt_q  <= '0;
          tx_bit_q  <= '0;
          tx_byte_q <= '0;
          uart_tx_q <= 1'b0;
          status3_q <= 1'b0;
          status4_q <= 1'b1;
          st_q      <= S_TX;
        end
        S_TX: begin
          tx_cnt_q <= tx_cnt_q + 16'd1;
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              if (tx_byte_q == 3'd7) begin
                st_q      <= S_IDLE;
                status4_q <= 1'b0;
              end else begin
                // Next start bit follows the stop bit directly: no idle gap.
                tx_byte_q <= tx_byte_q + 3'd1;
                tx_bit_q  <= '0;
                uart_tx_q <= 1'b0;
                tx_sh_q   <= result_q[63:56];
                result_q  <= {result_q[55:0], 8'h00};
              end
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              if (tx_bit_q == 4'd8) begin
                uart_tx_q <= 1'b1;
              end else begin
                uart_tx_q <= tx_sh_q[0];
                tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
              end
            end
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  des_core u_des (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (des_start_q),
    .decrypt_i (des_dec),
    .key_i     (key_q),
    .data_i    (payload_q),
    .done_o    (des_done),
    .data_o    (des_res)
  );
endmodule

// Iterative DES: one round per clock, done_o pulses 17 clocks after start_i.
module des_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        decrypt_i,
  input  logic [63:0] key_i,
  input  logic [63:0] data_i,
  output logic        done_o,
  output logic [63:0] data_o
);
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam logic [1:0] SHIFTS [16] = '{2'd1,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,
                                         2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd1};
  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Tables use DES numbering: entry n means bit n counted from the MSB, starting at 1.
  function automatic logic [63:0] perm64(input logic [63:0] x, input logic fin);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64 - (fin ? FP_T[i] : IP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = k[64 - PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56 - PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++) x[47-i] = r[32 - E_T[i]];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(SBOX[64*j + 16*int'({b[5], b[0]}) + int'(b[4:1])]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32 - P_T[i]];
    return p;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  logic [31:0] l_q, r_q, f_out;
  logic [27:0] c_q, d_q, c_use, d_use, c_nxt, d_nxt;
  logic [3:0]  rnd_q;
  logic [1:0]  sh;
  logic        busy_q, dec_q, done_q;
  logic [63:0] data_q, ip_out;
  logic [55:0] pc1_out;

  assign ip_out  = perm64(data_i, 1'b0);
  assign pc1_out = pc1(key_i);
  assign done_o  = done_q;
  assign data_o  = data_q;

  // Decryption walks the key schedule backwards: use C/D first, then rotate right.
  always_comb begin
    sh    = dec_q ? SHIFTS[4'd15 - rnd_q] : SHIFTS[rnd_q];
    c_use = dec_q ? c_q : rotl(c_q, sh);
    d_use = dec_q ? d_q : rotl(d_q, sh);
    c_nxt = dec_q ? rotr(c_q, sh) : c_use;
    d_nxt = dec_q ? rotr(d_q, sh) : d_use;
    f_out = feistel(r_q, pc2({c_use, d_use}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q <= '0; r_q <= '0; c_q <= '0; d_q <= '0;
      rnd_q <= '0; busy_q <= 1'b0; dec_q <= 1'b0; done_q <= 1'b0; data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        {l_q, r_q} <= ip_out;
        {c_q, d_q} <= pc1_out;
        dec_q      <= decrypt_i;
        rnd_q      <= '0;
        busy_q     <= 1'b1;
      end else if (busy_q) begin
        l_q   <= r_q;
        r_q   <= l_q ^ f_out;
        c_q   <= c_nxt;
        d_q   <= d_nxt;
        rnd_q <= rnd_q + 4'd1;
        if (rnd_q == 4'd15) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          data_q <= perm64({l_q ^ f_out, r_q}, 1'b1);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_uart_des.sv
// Directed bench for serial_uart_des: drives UART frames at 4 clk/bit, decodes uart_tx.
module tb_serial_uart_des;
  logic clk, rst_n, uart_rx;
  logic uart_tx, status1, status2, status3, status4;
  int   n_chk, n_pass, n_fail;

  serial_uart_des #(.CLK_FREQ(50), .BAUD(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .status1 (status1),
    .status2 (status2),
    .status3 (status3),
    .status4 (status4)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [63:0] pl);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(cmd, 1'b1);
    for (int i = 7; i >= 0; i--) send_byte(pl[8*i +: 8], 1'b1);
    uart_rx = 1'b1;
  endtask

  task automatic expect_tx(input string tag, input logic [63:0] exp);
    logic       seen, framing_ok;
    logic [7:0] b;
    seen = 1'b0;
    framing_ok = 1'b1;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) seen = 1'b1;
    end
    check({tag, " tx_start"}, 64'(seen), 64'd1);
    if (seen) begin
      repeat (2) @(negedge clk);
      check({tag, " status4"}, 64'(status4), 64'd1);
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        if (uart_tx !== 1'b1) framing_ok = 1'b0;
        check($sformatf("%s byte%0d", tag, k), 64'(b), 64'(exp[63-8*k -: 8]));
        if (k < 7) begin
          repeat (4) @(negedge clk);
          if (uart_tx !== 1'b0) framing_ok = 1'b0;
        end
      end
      check({tag, " framing"}, 64'(framing_ok), 64'd1);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic low;
    low = 1'b0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low = 1'b1;
    end
    check(tag, 64'(low), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst uart_tx", 64'(uart_tx), 64'd1);
    check("rst status1", 64'(status1), 64'd0);
    check("rst status2", 64'(status2), 64'd0);
    check("rst status3", 64'(status3), 64'd0);
    check("rst status4", 64'(status4), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Key load: 133457799BBCDFF1
    repeat (8) @(negedge clk);
    send_byte(8'hFF, 1'b1);
    check("key status2 busy", 64'(status2), 64'd1);
    send_byte(8'h13, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h57, 1'b1); send_byte(8'h79, 1'b1);
    send_byte(8'h9B, 1'b1); send_byte(8'hBC, 1'b1); send_byte(8'hDF, 1'b1); send_byte(8'hF1, 1'b1);
    uart_rx = 1'b1;
    expect_quiet("key no tx", 100);
    check("key status1", 64'(status1), 64'd1);
    check("key status2 idle", 64'(status2), 64'd0);
    check("key status3 idle", 64'(status3), 64'd0);

    send_frame(8'h0F, 64'h0123456789ABCDEF);
    expect_tx("enc", 64'h85E813540F0AB405);
    repeat (6) @(negedge clk);
    check("enc status4 done", 64'(status4), 64'd0);
    check("enc uart_tx idle", 64'(uart_tx), 64'd1);

    send_frame(8'hF0, 64'h85E813540F0AB405);
    expect_tx("dec", 64'h0123456789ABCDEF);
    repeat (6) @(negedge clk);

    send_frame(8'h55, 64'h0123456789ABCDEF);
    expect_quiet("other cmd no tx", 150);
    send_frame(8'h0F, 64'h0123456789ABCDEF);
    expect_tx("enc after 55", 64'h85E813540F0AB405);
    repeat (6) @(negedge clk);

    // Stop bit 0 in the middle of a frame drops the whole partial frame.
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h0F, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b0);
    uart_rx = 1'b1;
    expect_quiet("frame err no tx", 60);
    check("frame err status2", 64'(status2), 64'd0);
    send_frame(8'h0F, 64'h0123456789ABCDEF);
    expect_tx("enc after err", 64'h85E813540F0AB405);
    repeat (6) @(negedge clk);

    // Reset in the middle of a transmission.
    send_frame(8'h0F, 64'h0123456789ABCDEF);
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) seen = 1'b1;
    end
    check("mid tx start", 64'(seen), 64'd1);
    repeat (41) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst uart_tx", 64'(uart_tx), 64'd1);
    check("mid rst status1", 64'(status1), 64'd0);
    check("mid rst status2", 64'(status2), 64'd0);
    check("mid rst status3", 64'(status3), 64'd0);
    check("mid rst status4", 64'(status4), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h0F, 64'h0000000000000000);
    expect_tx("enc key0", 64'h8CA64DE9C1B123A7);
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
